// File: rtl/press_counter_pkg.sv
// press_counter_pkg: shared definitions for the debounced press counter.
//   state_t      - FSM state encoding (2-bit, IDLE=0 .. WAIT_RELEASE=3)
//   N_DEFAULT    - default debounce timer width (window = 2^N cycles)
//   LEDS_DEFAULT - default width of the press count / LED bus
package press_counter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int unsigned N_DEFAULT    = 6;
  localparam int unsigned LEDS_DEFAULT = 5;

endpackage

// File: rtl/press_counter_if.sv
// press_counter_if: board-side signals of the press counter.
//   btn   - raw button, asynchronous to clk, 1 = pressed
//   leds  - running press count
//   press - one-cycle pulse per accepted press
// Modports: master drives btn and observes the outputs; slave is the counter.
interface press_counter_if
  import press_counter_pkg::*;
#(
  parameter int unsigned LEDS = LEDS_DEFAULT
);

  logic            btn;
  logic [LEDS-1:0] leds;
  logic            press;

  modport master (output btn, input leds, input press);
  modport slave  (input btn, output leds, output press);

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous 1-bit input.
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronised output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/press_counter.sv
// press_counter: synchronises and debounces a pushbutton and counts clean presses.
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   bus.btn    - raw button input
//   bus.leds   - press count, wraps modulo 2^LEDS
//   bus.press  - registered one-cycle pulse per accepted press
// A level must hold for a full 2^N-cycle window in WAIT_PRESS / WAIT_RELEASE
// before the FSM moves on; any opposite level falls back with no partial credit.
module press_counter
  import press_counter_pkg::*;
#(
  parameter int unsigned N    = N_DEFAULT,
  parameter int unsigned LEDS = LEDS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  press_counter_if.slave  bus
);

  localparam logic [N-1:0] TIMER_MAX = '1;

  logic            s2;
  state_t          state_q, state_d;
  logic [N-1:0]    timer_q, timer_d;
  logic [LEDS-1:0] leds_q, leds_d;
  logic            press_q, press_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (s2)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    leds_d  = leds_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = WAIT_PRESS;
          timer_d = '0;
        end
      end
      WAIT_PRESS: begin
        // Level check first: a drop on the final timer cycle still rejects.
        if (!s2) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
          leds_d  = leds_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_d = WAIT_RELEASE;
          timer_d = '0;
        end
      end
      WAIT_RELEASE: begin
        // Re-entering PRESSED from here is a release bounce: no pulse, no count.
        if (s2) begin
          state_d = PRESSED;
        end else if (timer_q == TIMER_MAX) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      leds_q  <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      leds_q  <= leds_d;
      press_q <= press_d;
    end
  end

  assign bus.leds  = leds_q;
  assign bus.press = press_q;

endmodule

// File: doc/press_counter.md
# press_counter

Counts debounced pushbutton presses and shows the running count on the board LEDs. It is the input-side companion to the free-running LED counter: instead of driving a pattern out, it reads a raw, bouncing button, synchronises and debounces it, and advances a 5-bit LED count once per clean press. It sits between the iCE40 button pin and the LED pins.

## Interface
- N, default 6: debounce timer width. Each stability window is 2^N clock cycles.
- LEDS, default 5: width of the press count and of the LED bus.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  1  raw button, asynchronous to clk; 1 = pressed.
- leds  output  LEDS  press count.
- press  output  1  one-cycle pulse per accepted press.

## Operation
- **Synchroniser.** btn goes through two flops (s1, then s2). Only s2 is used downstream.
- **Timer.** N-bit, cleared to 0 on every entry to a WAIT state. Increments by 1 each cycle in WAIT while s2 holds the candidate level.
- **FSM states:** IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE: s2=1 → WAIT_PRESS (timer ← 0).
  - WAIT_PRESS:
    - s2=0 → IDLE (bounce rejected, no pulse).
    - timer=2^N−1 → PRESSED; press ← 1; leds ← leds+1.
    - otherwise timer+1.
  - PRESSED: s2=0 → WAIT_RELEASE (timer ← 0).
  - WAIT_RELEASE:
    - s2=1 → PRESSED (release bounce; no pulse, no count).
    - timer=2^N−1 → IDLE.
    - otherwise timer+1.
- **Count.** leds increments modulo 2^LEDS; 31 + 1 → 0 for LEDS=5, with no saturation and no flag.
- **press** is registered and high exactly one cycle per IDLE→…→PRESSED sequence. It is never asserted on a PRESSED re-entry from WAIT_RELEASE.

## Timing
- **Reset values:** s1=s2=0, state=IDLE, timer=0, leds=0, press=0.
- **rst priority.** rst dominates every other event in the same cycle, including a concurrent WAIT_PRESS→PRESSED transition: no pulse, no increment.
- **Reset mid-operation** abandons any WAIT or PRESSED state. After release of rst, a button still held must pass a full WAIT_PRESS window again to count.
- **Press latency.** Let edge e0 be the first edge sampling btn=1, with btn then stable.
  - s2=1 after e1; state=WAIT_PRESS after e2.
  - press=1 and leds updated after edge e(2+2^N). This is 2^N+3 edges counting e0: 67 for N=6.
  - press drops after the following edge.
- **Release.** Release completes (state IDLE) 2^N+3 edges after the first edge sampling btn=0.
- **Minimum repeat.** The minimum press-to-press period is therefore 2·(2^N+3) cycles plus hold time.
- **Bounce window.** Any s2 glitch inside a WAIT window restarts qualification from IDLE or PRESSED. There is no partial credit.
- **Boundary.** s2 changing on the exact cycle timer=2^N−1: the level check wins, and the state returns without a transition.

## Structure
- Shared package press_counter_pkg holds:
  - the FSM state encoding (2-bit constants IDLE=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3);
  - the default N and LEDS.
- One sub-module, sync_2ff: a two-flop synchroniser with clk, rst and 1-bit d/q, reset to 0. It is reusable for other board inputs.
- Top level: FSM, timer and count register. Expected size 120–200 lines.

## Test plan
- **Reset:** hold rst 3 cycles with btn=1 → leds=0, press=0, no pulse until 67 cycles after rst falls (N=6).
- **Clean press:** btn 0→1 held 100 cycles, then 0 for 100 cycles → exactly one press pulse at edge 67, leds=1, state IDLE at end.
- **Bounce:** btn toggles 1/0 every 10 cycles for 60 cycles, then steady 1 → one pulse, 67 edges after the last rising edge; leds=1. Release bouncing 5 times → no extra pulse.
- **Wrap:** 33 clean presses → leds reads 1 after press 33; after press 32 it reads 0.
- **Mid-operation reset:** assert rst at cycle 40 of WAIT_PRESS, and separately on the exact cycle of the transition → no pulse, leds unchanged at 0.
- **Glitch at boundary:** s2 drops on the timer=63 cycle → no pulse, state IDLE.
